// File: rtl/add_serial_ctrl.sv
// Purpose  : nibble-serial wide adder/subtractor; one shared 4-bit adder, carry chained via register.
// Latency  : accept at edge t0, result valid from t0+NIBBLES; next accept no earlier than t0+NIBBLES+2.
// Backpr.  : in_ready low outside IDLE; result held in DONE until out_ready, then back to IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake carrying a, b, c_in, sub
//   out_valid/out_ready result handshake carrying sum, c_out
//   busy                high whenever the controller is not idle

module add_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_i,
    output logic [3:0] s,
    output logic       c_o
);
    assign {c_o, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_i};
endmodule

module add_serial_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   busy
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands and result viewed as arrays of nibbles so idx selects a slice directly.
    logic [NIBBLES-1:0][3:0] op_a;
    logic [NIBBLES-1:0][3:0] op_b;
    logic [NIBBLES-1:0][3:0] sum_r;
    logic [IW-1:0]           idx;
    logic                    cr;

    logic       accept;
    logic       last_nib;
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_s;
    logic       nib_c;

    assign nib_a = op_a[idx];
    assign nib_b = op_b[idx];

    add_4bit u_add (
        .a   (nib_a),
        .b   (nib_b),
        .c_i (cr),
        .s   (nib_s),
        .c_o (nib_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Decoded outputs / control strobes
    always_comb begin
        in_ready = (state == IDLE) & ~rst;
        busy     = (state != IDLE);
        accept   = in_valid & in_ready;
        last_nib = (state == RUN) && (idx == LAST);
    end

    // Datapath: operand capture, nibble stepping, registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sum_r     <= '0;
            idx       <= '0;
            cr        <= 1'b0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                op_a  <= a;
                // Subtraction is a + ~b + 1: invert here, inject the +1 as initial carry.
                op_b  <= sub ? ~b : b;
                cr    <= sub ? 1'b1 : c_in;
                idx   <= '0;
                sum_r <= '0;
            end else if (state == RUN) begin
                sum_r[idx] <= nib_s;
                cr         <= nib_c;
                if (last_nib) begin
                    c_out <= nib_c;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign sum = sum_r;

endmodule

// File: tb/tb_add_serial_ctrl.sv
module tb_add_serial_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // index 0: NIBBLES=4 instance, index 1: NIBBLES=2 instance
    logic        iv[2];
    logic        ordy[2];
    logic        cin[2];
    logic        sb[2];
    logic [15:0] av[2];
    logic [15:0] bv[2];
    logic        irdy[2];
    logic        ov[2];
    logic        co[2];
    logic        bz[2];
    logic [15:0] s4;
    logic [7:0]  s2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    add_serial_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(av[0]), .b(bv[0]), .c_in(cin[0]), .sub(sb[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s4), .c_out(co[0]), .busy(bz[0])
    );

    add_serial_ctrl #(.NIBBLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]), .c_in(cin[1]), .sub(sb[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s2), .c_out(co[1]), .busy(bz[1])
    );

    function automatic logic [15:0] sum_of(input int d);
        return (d == 0) ? s4 : {8'h00, s2};
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    // Reference: {c_out,sum} = a + (sub ? ~b+1 : b+c_in) modulo 2^(W+1)
    function automatic logic [16:0] ref_res(input int d, input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic s);
        logic [16:0] mask;
        logic [16:0] bb;
        logic [16:0] r;
        mask = (17'd1 << width_of(d)) - 17'd1;
        bb   = s ? ((~{1'b0, b}) & mask) : ({1'b0, b} & mask);
        r    = ({1'b0, a} & mask) + bb + (s ? 17'd1 : {16'd0, ci});
        return r & ((mask << 1) | 17'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s);
        bit ok;
        ok = 1'b0;
        av[d] = a; bv[d] = b; cin[d] = ci; sb[d] = s; iv[d] = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (irdy[d]) ok = 1'b1;
            step();
        end
        iv[d] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout dut=%0d in_ready never rose", d);
        end
    endtask

    task automatic wait_result(input int d, output logic [15:0] s, output logic c, output int lat);
        lat = 0;
        while (!ov[d] && lat < 40) begin
            step();
            lat++;
        end
        s = sum_of(d);
        c = co[d];
        total++;
        if (!ov[d]) begin
            bad++;
            $display("FAIL result_timeout dut=%0d out_valid=%0b required 1", d, ov[d]);
        end
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, output logic [15:0] so, output logic c);
        int lat;
        ordy[d] = 1'b1;
        accept(d, a, b, ci, s);
        wait_result(d, so, c, lat);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv[0] = 1'b1; iv[1] = 1'b1;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        step();
        step();
        total++;
        if (irdy[0] !== 1'b0 || irdy[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%0b/%0b required 0/0", irdy[0], irdy[1]);
        end
        rst = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0;
        #1;
        total++;
        if (ov[0] !== 1'b0 || s4 !== 16'h0 || co[0] !== 1'b0 || bz[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_state4 ov=%0b sum=%h co=%0b busy=%0b rdy=%0b required 0 0000 0 0 1",
                     ov[0], s4, co[0], bz[0], irdy[0]);
        end
        total++;
        if (ov[1] !== 1'b0 || s2 !== 8'h0 || co[1] !== 1'b0 || bz[1] !== 1'b0 || irdy[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_state2 ov=%0b sum=%h co=%0b busy=%0b rdy=%0b required 0 00 0 0 1",
                     ov[1], s2, co[1], bz[1], irdy[1]);
        end
    endtask

    task automatic test_basic();
        ordy[0] = 1'b1;
        accept(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (bz[0] !== 1'b1 || ov[0] !== (k == 4)) begin
                bad++;
                $display("FAIL basic_timing cycle=%0d busy=%0b ov=%0b required 1 %0b", k, bz[0], ov[0], (k == 4));
            end
        end
        total++;
        if (s4 !== 16'h2345 || co[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum got=%h/%0b required 2345/0", s4, co[0]);
        end
        step();
        total++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_release ov=%0b rdy=%0b required 0 1", ov[0], irdy[0]);
        end
    endtask

    task automatic test_ripple();
        logic [15:0] s;
        logic        c;
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c);
        total++;
        if (s !== 16'h0000 || c !== 1'b1) begin
            bad++;
            $display("FAIL ripple_b1 got=%h/%0b required 0000/1", s, c);
        end
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c);
        total++;
        if (s !== 16'h0000 || c !== 1'b1) begin
            bad++;
            $display("FAIL ripple_cin got=%h/%0b required 0000/1", s, c);
        end
    endtask

    task automatic test_subtract();
        logic [15:0] s;
        logic        c;
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, s, c);
        total++;
        if (s !== 16'hFFFE || c !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow got=%h/%0b required fffe/0", s, c);
        end
        run_op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, s, c);
        total++;
        if (s !== 16'h0002 || c !== 1'b1) begin
            bad++;
            $display("FAIL sub_noborrow got=%h/%0b required 0002/1", s, c);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        c;
        int          lat;
        bit          stable;
        ordy[0] = 1'b0;
        accept(0, 16'h00F0, 16'h0F0F, 1'b1, 1'b0);
        wait_result(0, s, c, lat);
        total++;
        if (s !== 16'h1000 || c !== 1'b0 || lat !== 4) begin
            bad++;
            $display("FAIL bp_result got=%h/%0b lat=%0d required 1000/0 lat=4", s, c, lat);
        end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            av[0] = 16'($urandom); bv[0] = 16'($urandom); cin[0] = 1'b0; sb[0] = 1'b0;
            iv[0] = 1'b1;
            step();
            if (ov[0] !== 1'b1 || s4 !== s || co[0] !== c || irdy[0] !== 1'b0) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold ov=%0b sum=%h co=%0b rdy=%0b required 1 %h %0b 0", ov[0], s4, co[0], irdy[0], s, c);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        step();
        total++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release ov=%0b rdy=%0b required 0 1", ov[0], irdy[0]);
        end
        run_op(0, 16'h8000, 16'h8001, 1'b0, 1'b0, s, c);
        total++;
        if (s !== 16'h0001 || c !== 1'b1) begin
            bad++;
            $display("FAIL bp_next got=%h/%0b required 0001/1", s, c);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        logic        c;
        bit          quiet;
        ordy[0] = 1'b1;
        accept(0, 16'h5555, 16'h3333, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (ov[0] !== 1'b0 || s4 !== 16'h0 || co[0] !== 1'b0 || bz[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state ov=%0b sum=%h co=%0b busy=%0b rdy=%0b required 0 0000 0 0 1",
                     ov[0], s4, co[0], bz[0], irdy[0]);
        end
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ov[0] !== 1'b0 || bz[0] !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL midrst_noresult ov=%0b busy=%0b required 0 0", ov[0], bz[0]);
        end
        run_op(0, 16'hABCD, 16'h1234, 1'b0, 1'b0, s, c);
        total++;
        if (s !== 16'hBE01 || c !== 1'b0) begin
            bad++;
            $display("FAIL midrst_next got=%h/%0b required be01/0", s, c);
        end
    endtask

    task automatic test_random(input int d);
        logic [16:0] q[$];
        int          got;
        int          limit;
        int          n;
        int          w;
        got   = 0;
        n     = 1000;
        limit = cyc + 30000;
        w     = width_of(d);
        iv[d] = 1'b0;
        ordy[d] = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [15:0] ra;
                    logic [15:0] rb;
                    logic        rc;
                    logic        rs;
                    repeat ($urandom_range(0, 2)) step();
                    ra = 16'($urandom); rb = 16'($urandom);
                    if (d == 1) begin ra = ra & 16'h00FF; rb = rb & 16'h00FF; end
                    rc = 1'($urandom); rs = 1'($urandom);
                    av[d] = ra; bv[d] = rb; cin[d] = rc; sb[d] = rs; iv[d] = 1'b1;
                    while (!irdy[d] && cyc < limit) step();
                    if (!irdy[d]) break;
                    q.push_back(ref_res(d, ra, rb, rc, rs));
                    step();
                    iv[d] = 1'b0;
                end
                iv[d] = 1'b0;
            end
            begin
                while (got < n && cyc < limit) begin
                    ordy[d] = ($urandom_range(0, 3) != 0);
                    if (ov[d] && ordy[d]) begin
                        logic [16:0] e;
                        logic [15:0] es;
                        e  = (q.size() > 0) ? q.pop_front() : 17'h1FFFF;
                        es = e[15:0] & 16'((17'd1 << w) - 17'd1);
                        total++;
                        if (sum_of(d) !== es || co[d] !== e[w]) begin
                            bad++;
                            $display("FAIL rand_result dut=%0d op=%0d got=%h/%0b required %h/%0b",
                                     d, got, sum_of(d), co[d], es, e[w]);
                        end
                        got++;
                    end
                    step();
                end
                ordy[d] = 1'b1;
            end
        join
        total++;
        if (got != n || q.size() != 0) begin
            bad++;
            $display("FAIL rand_count dut=%0d results=%0d pending=%0d required %0d 0", d, got, q.size(), n);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; cin[i] = 1'b0; sb[i] = 1'b0;
            av[i] = 16'h0; bv[i] = 16'h0;
        end
        test_reset();
        test_basic();
        test_ripple();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_random(1);
        test_random(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
